// File: rtl/text_term.sv
// text_term: character-terminal engine for the PS/2-to-VGA text path.
// Keeps a ROWS x COLS character buffer addressed through a circular row
// offset (top), so scrolling is a pointer bump followed by clearing one row.
// A registered, read-first port serves the VGA character-cell fetch.
module text_term #(
  parameter int COLS = 70,
  parameter int ROWS = 30,
  parameter int XW   = 7,
  parameter int YW   = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_ascii,
  output logic          in_ready,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic [7:0]    rd_ascii,
  output logic          rd_is_cursor,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y
);

  localparam int CELLS = ROWS * COLS;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [1:0] {
    INIT_CLR,
    IDLE,
    LINE_CLR
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_nextCnt;
  logic [YW-1:0] r_top;
  logic [YW-1:0] w_nextTop;
  logic [XW-1:0] r_curX;
  logic [XW-1:0] w_nextX;
  logic [YW-1:0] r_curY;
  logic [YW-1:0] w_nextY;

  logic          w_we;
  logic [AW-1:0] w_wAddr;
  logic [7:0]    w_wData;
  logic          w_doNewline;

  logic [7:0]    r_mem [CELLS];
  logic [7:0]    r_rdAscii;
  logic          r_rdIsCursor;

  logic          w_rdInRange;
  logic [AW-1:0] w_rdAddr;
  logic [YW-1:0] w_bottomPhys;
  logic          w_printable;

  // Logical row to physical row through the circular top offset.
  function automatic logic [YW-1:0] physRow(input logic [YW-1:0] y,
                                            input logic [YW-1:0] top);
    logic [YW:0] s;
    s = {1'b0, y} + {1'b0, top};
    if (s >= (YW+1)'(ROWS)) s = s - (YW+1)'(ROWS);
    return s[YW-1:0];
  endfunction

  // Flat buffer address of a physical row and column.
  function automatic logic [AW-1:0] cellAddr(input logic [YW-1:0] phys,
                                             input logic [XW-1:0] x);
    return AW'(phys) * AW'(COLS) + AW'(x);
  endfunction

  assign w_rdInRange  = ({1'b0, rd_x} < (XW+1)'(COLS)) &&
                        ({1'b0, rd_y} < (YW+1)'(ROWS));
  assign w_rdAddr     = cellAddr(physRow(rd_y, r_top), rd_x);
  assign w_bottomPhys = (r_top == '0) ? YW'(ROWS - 1) : r_top - YW'(1);
  assign w_printable  = (in_ascii >= 8'h20) && (in_ascii <= 8'h7E);

  // Next-state, cursor/top updates and the single buffer write port.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextTop   = r_top;
    w_nextX     = r_curX;
    w_nextY     = r_curY;
    w_we        = 1'b0;
    w_wAddr     = '0;
    w_wData     = 8'h20;
    w_doNewline = 1'b0;
    case (r_state)
      INIT_CLR: begin
        w_we    = 1'b1;
        w_wAddr = r_cnt;
        if (r_cnt == AW'(CELLS - 1)) begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + AW'(1);
        end
      end
      LINE_CLR: begin
        w_we    = 1'b1;
        w_wAddr = cellAddr(w_bottomPhys, XW'(r_cnt));
        if (r_cnt == AW'(COLS - 1)) begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + AW'(1);
        end
      end
      IDLE: begin
        if (in_valid) begin
          if (w_printable) begin
            w_we    = 1'b1;
            w_wAddr = cellAddr(physRow(r_curY, r_top), r_curX);
            w_wData = in_ascii;
            if (r_curX < XW'(COLS - 1)) w_nextX = r_curX + XW'(1);
            else                        w_doNewline = 1'b1;
          end else if (in_ascii == 8'h0A) begin
            w_doNewline = 1'b1;
          end else if (in_ascii == 8'h0D) begin
            w_nextX = '0;
          end else if (in_ascii == 8'h08) begin
            if (r_curX != '0) begin
              w_nextX = r_curX - XW'(1);
              w_we    = 1'b1;
              w_wAddr = cellAddr(physRow(r_curY, r_top), r_curX - XW'(1));
            end else if (r_curY != '0) begin
              w_nextX = XW'(COLS - 1);
              w_nextY = r_curY - YW'(1);
              w_we    = 1'b1;
              w_wAddr = cellAddr(physRow(r_curY - YW'(1), r_top), XW'(COLS - 1));
            end
          end
        end
      end
      default: w_nextState = INIT_CLR;
    endcase
    if (w_doNewline) begin
      w_nextX = '0;
      if (r_curY < YW'(ROWS - 1)) begin
        w_nextY = r_curY + YW'(1);
      end else begin
        w_nextTop   = (r_top == YW'(ROWS - 1)) ? '0 : r_top + YW'(1);
        w_nextState = LINE_CLR;
        w_nextCnt   = '0;
      end
    end
    if (!reset) w_we = 1'b0;
  end

  // State, clear counter, scroll offset and cursor registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= INIT_CLR;
      r_cnt   <= '0;
      r_top   <= '0;
      r_curX  <= '0;
      r_curY  <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_top   <= w_nextTop;
      r_curX  <= w_nextX;
      r_curY  <= w_nextY;
    end
  end

  // Character buffer write; the buffer itself has no reset.
  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_wAddr] <= w_wData;
  end

  // Registered read-first fetch for the display; blank while initialising.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rdAscii    <= 8'h20;
      r_rdIsCursor <= 1'b0;
    end else if (r_state == INIT_CLR) begin
      r_rdAscii    <= 8'h20;
      r_rdIsCursor <= 1'b0;
    end else begin
      r_rdAscii    <= w_rdInRange ? r_mem[w_rdAddr] : 8'h20;
      r_rdIsCursor <= (rd_x == r_curX) && (rd_y == r_curY);
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign rd_ascii     = r_rdAscii;
  assign rd_is_cursor = r_rdIsCursor;
  assign cur_x        = r_curX;
  assign cur_y        = r_curY;

endmodule

// File: tb/tb_text_term.sv
// tb_text_term: randomized and directed stimulus for text_term against a
// screen model that scrolls by physically shifting rows.
module tb_text_term;

  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int XW    = 2;
  localparam int YW    = 2;
  localparam int CELLS = ROWS * COLS;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_ascii = 8'h00;
  logic          in_ready;
  logic [XW-1:0] rd_x = '0;
  logic [YW-1:0] rd_y = '0;
  logic [7:0]    rd_ascii;
  logic          rd_is_cursor;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;

  text_term #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ascii(in_ascii), .in_ready(in_ready),
    .rd_x(rd_x), .rd_y(rd_y), .rd_ascii(rd_ascii), .rd_is_cursor(rd_is_cursor),
    .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clock = ~clock;

  int nVec = 0;
  int nMis = 0;

  // Reference screen: logical rows, scrolled by copying rows upward.
  logic [7:0] mScreen [ROWS][COLS];
  int mX = 0;
  int mY = 0;

  typedef struct { logic [7:0] ascii; logic isCur; int x; int y; } rdExp_t;
  typedef struct { int x; int y; } curExp_t;
  rdExp_t  rdQ[$];
  curExp_t curQ[$];

  logic rdReq  = 1'b0;
  logic hsPipe = 1'b0;
  logic rdPipe = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelClear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mScreen[r][c] = 8'h20;
    mX = 0;
    mY = 0;
  endtask

  task automatic modelNewline(output int scrolled);
    scrolled = 0;
    mX = 0;
    if (mY < ROWS - 1) begin
      mY++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) mScreen[r][c] = mScreen[r+1][c];
      for (int c = 0; c < COLS; c++) mScreen[ROWS-1][c] = 8'h20;
      scrolled = 1;
    end
  endtask

  task automatic modelApply(input logic [7:0] b, output int scrolled);
    scrolled = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      mScreen[mY][mX] = b;
      if (mX < COLS - 1) mX++;
      else modelNewline(scrolled);
    end else if (b == 8'h0A) begin
      modelNewline(scrolled);
    end else if (b == 8'h0D) begin
      mX = 0;
    end else if (b == 8'h08) begin
      if (mX > 0) begin
        mX--;
        mScreen[mY][mX] = 8'h20;
      end else if (mY > 0) begin
        mY--;
        mX = COLS - 1;
        mScreen[mY][mX] = 8'h20;
      end
    end
  endtask

  // Handshake and read-issue recorder, sampled on the active edge.
  always @(posedge clock) begin
    hsPipe <= reset && in_valid && in_ready;
    rdPipe <= rdReq;
  end

  // Monitor: pops the expected cursor after each accepted byte and the
  // expected cell after each issued read, comparing away from the edge.
  always @(negedge clock) begin
    if (hsPipe) begin
      if (curQ.size() == 0) begin
        nVec++; nMis++;
        $display("[TB] FAIL cursor-queue-empty: got accept, expected none");
      end else begin
        curExp_t e;
        e = curQ.pop_front();
        nVec++;
        if (cur_x !== XW'(e.x) || cur_y !== YW'(e.y)) begin
          nMis++;
          $display("[TB] FAIL cursor: got (%0d,%0d), expected (%0d,%0d)",
                   cur_x, cur_y, e.x, e.y);
        end
      end
    end
    if (rdPipe) begin
      if (rdQ.size() == 0) begin
        nVec++; nMis++;
        $display("[TB] FAIL read-queue-empty: got read, expected none");
      end else begin
        rdExp_t e;
        e = rdQ.pop_front();
        nVec++;
        if (rd_ascii !== e.ascii || rd_is_cursor !== e.isCur) begin
          nMis++;
          $display("[TB] FAIL read(%0d,%0d): got %02h/%0b, expected %02h/%0b",
                   e.x, e.y, rd_ascii, rd_is_cursor, e.ascii, e.isCur);
        end
      end
    end
  end

  // Offers one byte, waits for the handshake, and optionally measures the
  // not-ready window that a scroll produces. Starts and ends on a negedge.
  task automatic applyStimulus(input logic [7:0] b, input bit waitStall,
                               output int waited);
    int scrolled;
    int n;
    in_valid = 1'b1;
    in_ascii = b;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      nVec++; nMis++;
      $display("[TB] FAIL handshake-timeout: got no ready, expected ready for %02h", b);
      in_valid = 1'b0;
      return;
    end
    modelApply(b, scrolled);
    curQ.push_back('{mX, mY});
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    if (waitStall && scrolled != 0) begin
      n = 0;
      while (!in_ready && n < 200) begin
        @(negedge clock);
        n++;
      end
      checkOutput("scroll-stall-cycles", n, COLS);
    end
  endtask

  task automatic sendString(input string s);
    int w;
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1, w);
  endtask

  task automatic readCell(input int x, input int y, input bit inInit);
    rdExp_t e;
    rd_x = x[XW-1:0];
    rd_y = y[YW-1:0];
    rdReq = 1'b1;
    e.x = x;
    e.y = y;
    if (inInit || x >= COLS || y >= ROWS) begin
      e.ascii = 8'h20;
      e.isCur = 1'b0;
    end else begin
      e.ascii = mScreen[y][x];
      e.isCur = (x == mX) && (y == mY);
    end
    rdQ.push_back(e);
    @(negedge clock);
    rdReq = 1'b0;
  endtask

  task automatic readScreen();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) readCell(x, y, 1'b0);
  endtask

  // Holds reset, checks the reset values, then measures the clear time.
  task automatic applyReset(input int holdCycles);
    int n;
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (holdCycles) @(negedge clock);
    checkOutput("reset-cur-x", cur_x, 0);
    checkOutput("reset-cur-y", cur_y, 0);
    checkOutput("reset-in-ready", in_ready, 0);
    checkOutput("reset-rd-ascii", rd_ascii, 8'h20);
    checkOutput("reset-rd-is-cursor", rd_is_cursor, 0);
    reset = 1'b1;
    modelClear();
    readCell(0, 0, 1'b1);
    n = 1;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput("init-clear-cycles", n, CELLS);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    logic [7:0] b;
    modelClear();
    @(negedge clock);

    // Reset and clear
    applyReset(2);
    readScreen();

    // Print and wrap
    sendString("ABCD");
    checkOutput("wrap-cur-x", cur_x, 0);
    checkOutput("wrap-cur-y", cur_y, 1);
    sendString("E");
    checkOutput("after-e-cur-x", cur_x, 1);
    readScreen();

    // Scroll
    applyReset(2);
    sendString("A\nB\nC\n");
    checkOutput("scroll-cur-y", cur_y, 2);
    readCell(0, 0, 1'b0);
    readScreen();
    readCell(1, 3, 1'b0);

    // Backspace
    applyReset(1);
    sendString("AB");
    sendString("\010\010\010");
    checkOutput("bs-home-cur-x", cur_x, 0);
    checkOutput("bs-home-cur-y", cur_y, 0);
    sendString("ABCDE");
    sendString("\010\010");
    checkOutput("bs-up-cur-x", cur_x, 3);
    checkOutput("bs-up-cur-y", cur_y, 0);
    readScreen();

    // Ignored code, CR, and a byte held across a line clear
    sendString("\rAB");
    applyStimulus(8'h07, 1'b1, w);
    checkOutput("bel-cur-x", cur_x, 2);
    applyStimulus(8'h0D, 1'b1, w);
    checkOutput("cr-cur-x", cur_x, 0);
    sendString("\n\n");
    applyStimulus(8'h0A, 1'b0, w);
    applyStimulus("X", 1'b1, w);
    checkOutput("held-during-clear", w, COLS);
    readScreen();

    // Reset on the second line-clear cycle
    applyReset(1);
    sendString("\n\n");
    applyStimulus(8'h0A, 1'b0, w);
    @(negedge clock);
    applyReset(1);
    readScreen();

    // Randomized byte stream with periodic full-screen checks
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'h0A;
        1:       b = 8'h0D;
        2, 3:    b = 8'h08;
        4:       b = 8'($urandom_range(0, 31));
        default: b = 8'($urandom_range(32, 126));
      endcase
      applyStimulus(b, 1'b1, w);
      if (i % 50 == 49) begin
        readScreen();
        readCell(int'($urandom_range(0, COLS - 1)), 3, 1'b0);
      end
    end

    repeat (3) @(negedge clock);
    checkOutput("queues-drained", curQ.size() + rdQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/text_term.md
# text_term

Parametrised character-terminal engine for the PS/2-to-VGA text path. It accepts ASCII bytes over a valid/ready handshake and keeps a ROWS×COLS character buffer with a cursor. It handles printable characters, backspace, CR and LF, auto-wraps at the line end, and scrolls by rotating a circular row offset, then clears the freshly exposed line. A registered read port serves the VGA character-cell fetch, so this block replaces the fixed-size video memory in the display path.

## Interface
- COLS, 70, characters per line (≥2)
- ROWS, 30, lines per screen (≥2)
- XW, 7, column index width; 2^XW ≥ COLS
- YW, 5, row index width; 2^YW ≥ ROWS

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- in_valid  in  1  in_ascii holds a byte to consume
- in_ascii  in  8  ASCII byte
- in_ready  out  1  block can accept a byte this cycle
- rd_x  in  XW  display column to fetch
- rd_y  in  YW  display (logical) row to fetch
- rd_ascii  out  8  character at (rd_x, rd_y), registered
- rd_is_cursor  out  1  (rd_x, rd_y) equals the cursor, registered
- cur_x  out  XW  cursor column
- cur_y  out  YW  cursor logical row

## Operation
- Storage: ROWS*COLS bytes. The physical address is phys_row*COLS + x.
  - phys_row = top + y; subtract ROWS if the result ≥ ROWS.
  - top is a YW-bit register, range 0..ROWS-1, reset value 0.
- States: INIT_CLR, IDLE, LINE_CLR. in_ready = (state == IDLE).
- INIT_CLR:
  - Entered on reset.
  - Writes 0x20 to addresses 0..ROWS*COLS-1, one per cycle, then goes to IDLE.
- Byte handling: a byte is consumed on a cycle where in_valid && in_ready.
  - 0x20..0x7E: write the byte at the cursor. If cur_x < COLS-1, cur_x+1; else perform a newline (auto-wrap).
  - 0x0A: newline.
  - 0x0D: cur_x = 0.
  - 0x08, cur_x > 0: cur_x-1, then write 0x20 at the new position.
  - 0x08, cur_x = 0 and cur_y > 0: cur_y-1, cur_x = COLS-1, then write 0x20 there.
  - 0x08 at (0,0): no-op.
  - Any other value: consumed and ignored; no state change.
- Newline:
  - Always sets cur_x = 0.
  - If cur_y < ROWS-1: cur_y+1, stay in IDLE.
  - Else (scroll): cur_y is unchanged. top = (top+1) mod ROWS. Enter LINE_CLR.
- LINE_CLR:
  - Writes 0x20 to the COLS cells of the new bottom physical row (the old top row), one per cycle, then returns to IDLE.
- Read port:
  - rd_ascii = stored byte at (rd_x, rd_y) through the current top.
  - rd_x ≥ COLS or rd_y ≥ ROWS returns 0x20.
  - In INIT_CLR, rd_ascii is forced to 0x20 and rd_is_cursor to 0.
  - In LINE_CLR, reads return memory contents as they are.
- Read during write to the same cell returns the old byte (read-first).

## Timing
- Reset (reset=0 at an edge) forces these values at that edge:
  - state = INIT_CLR, clear counter 0, top 0.
  - cur_x 0, cur_y 0.
  - rd_ascii 0x20, rd_is_cursor 0, in_ready 0.
- in_ready first goes high exactly ROWS*COLS cycles after the first edge with reset=1.
- Reset asserted mid-operation (any state) aborts at once and restarts INIT_CLR.
- A byte accepted at edge N:
  - Cell write and cursor/top update take effect at edge N.
  - A read issued in cycle N+1 shows the new data on rd_ascii after edge N+1.
- Read latency is 1 cycle: rd_x/rd_y sampled at edge N appear on rd_ascii/rd_is_cursor after edge N.
- Scroll timing:
  - in_ready is low for exactly COLS cycles after the accepting edge.
  - in_ready is high again in cycle N+COLS+1.
- Throughput is one byte per cycle in IDLE when no scroll occurs; backspace and wrap take no extra cycles.
- in_ascii is ignored whenever in_ready = 0; the producer must hold it until the handshake completes.

## Test plan
All cases use COLS=4, ROWS=3.
1. Reset and clear:
   - Hold reset=0 for 2 cycles, release. in_ready stays 0 for 12 cycles, then rises.
   - Reading all 12 cells returns 0x20; rd_is_cursor is 1 only at (0,0).
2. Print and wrap:
   - Send "ABCD". Row 0 = "ABCD"; cursor (0,1) after the fourth byte.
   - Send "E". (0,1) = 'E'; cursor (1,1).
3. Scroll:
   - From a clear screen, send "A\nB\nC\n". The third LF triggers a scroll and in_ready drops for 4 cycles.
   - Afterwards row 0 = "B", row 1 = "C", row 2 all 0x20; cursor (0,2); top = 1.
4. Backspace:
   - Send "AB", then 0x08, 0x08, 0x08. Cells (0,0) and (1,0) become 0x20; cursor (0,0); the third 0x08 is a no-op.
   - Send "ABCDE", then 0x08 twice. Cursor goes to (3,0); cell (3,0) = 0x20.
5. Handshake and ignored codes:
   - Drive in_valid with 0x07 and 0x0D mid-line. Both are consumed; 0x07 changes nothing; 0x0D sets cur_x = 0.
   - A byte driven during LINE_CLR is not consumed until in_ready=1.
6. Reset mid-LINE_CLR:
   - Assert reset=0 on the 2nd clear cycle. At that edge cur=(0,0), top=0, in_ready=0.
   - After release, in_ready rises after 12 cycles and the full screen reads 0x20.
